shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Multi-cycle shift unit controller: accepts one shift request per start pulse and sequences it over several cycles, moving at most STEP bit positions per cycle.
- Gives the same results as the single-cycle combinational shifter, using a small datapath.
- Sits between the execute-stage control and the register-file writeback.
- Signals completion with a one-cycle done pulse and a stable result register.

Parameters:
- STEP, 4: maximum bit positions shifted per cycle. Must be a power of two, 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled on a clk edge while accepting (IDLE or DONE).
- a  input  32  operand; treated as signed for arithmetic right shift.
- shiftamt  input  32  unsigned shift amount.
- op1  input  1  mode bit 1.
- op2  input  1  mode bit 2.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse; high exactly while in DONE.
- res  output  32  result; valid when done=1; held until the next completion.

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high. While rst=1: state=IDLE, busy=0, done=0, res=0, internal work/remaining/mode registers=0.
- Reset mid-operation aborts the request. No done pulse is produced and res reads 0.
- Modes {op1,op2}:
  - 00 = shll, zero fill.
  - 10 = shrl, zero fill.
  - 01 = shra, sign fill from a[31].
  - 11 = invalid; result 0.
- States: IDLE, SHIFT, DONE.
- Accept: on an edge in IDLE or DONE with start=1, capture into the work register, mode register and rem register:
  - work = a.
  - mode = {op1,op2}.
  - rem = min(shiftamt, 32), saturating; amounts >= 32 clamp to 32.
  - If mode=11: work = 0 and rem = 0.
  - Next state = SHIFT if rem != 0, else DONE.
- SHIFT, each edge:
  - s = min(STEP, rem).
  - work shifted by s per mode.
  - rem -= s.
  - If the new rem = 0: res <= shifted work, next state = DONE.
- DONE: done=1 for exactly one cycle.
  - With start=1: accept a new request (back-to-back).
  - Otherwise: go to IDLE.
- Zero-amount or invalid requests: res is loaded at the accept edge and the FSM goes directly to DONE.
- Latency: let N = ceil(min(shiftamt,32)/STEP), with N=0 for mode 11. Accept at edge k; done is high in the cycle following edge k+N. Worst case is 32/STEP shift cycles plus the DONE cycle.
- Saturation:
  - Clamped 32-bit shll/shrl yields 0.
  - Clamped shra yields 0x00000000 or 0xFFFFFFFF per a[31].
- start while in SHIFT: ignored, no queuing. Inputs are not sampled outside accept edges.
- res changes only on the edge entering DONE; it is stable through SHIFT and IDLE.
- busy = (state==SHIFT), done = (state==DONE); both are registered state decodes with no combinational path from start.

Test Plan:
- STEP=4; accept a=0x00000001, shiftamt=5, mode 00 -> busy for 2 cycles, done pulses in the 3rd cycle after the accept edge, res=0x00000020.
- a=0x80000000, shiftamt=31, mode 01 -> 8 SHIFT cycles then done, res=0xFFFFFFFF. Same operand with mode 10 -> res=0x00000001.
- a=0x80000000, shiftamt=40 (clamped), mode 10 -> 8 SHIFT cycles, res=0x00000000. Mode 01 -> res=0xFFFFFFFF.
- shiftamt=0, a=0x12345678, mode 00 -> busy never asserts, done in the cycle after accept, res=0x12345678. Mode 11 with any a -> same timing, res=0x00000000.
- Request (a=0xF0, amt=8, mode 10) with start re-pulsed carrying different data during SHIFT -> second pulse ignored, res=0x00000000 after 2 shift cycles. start held high in DONE with a=3, amt=1, mode 00 -> back-to-back accept, next done gives res=0x00000006.
- Assert rst during SHIFT of a 32-bit shift -> busy, done and res go to 0 immediately (asynchronously). No done pulse after release. A fresh request then completes normally.

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle shift controller. One request is accepted per start pulse and
//   then shifted over several cycles, at most STEP bit positions per cycle.
//   The final value matches a single-cycle combinational shifter.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset, aborts any request in flight
//   start     request strobe, only looked at while in IDLE or DONE
//   a         32-bit operand (signed for arithmetic right shift)
//   shiftamt  32-bit unsigned shift amount, saturates at 32
//   op1, op2  mode: 00 shll, 10 shrl, 01 shra, 11 invalid (result 0)
//   busy      high while shifting
//   done      one-cycle completion pulse
//   res       result register, updated only when entering DONE
module shift_sequencer #(
   parameter int STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] shiftamt,
   input  logic        op1,
   input  logic        op2,
   output logic        busy,
   output logic        done,
   output logic [31:0] res
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateT;

   localparam logic [5:0] stepMax = 6'(STEP);

   stateT       state;
   stateT       nextState;
   logic [31:0] work;
   logic [1:0]  mode;
   logic [5:0]  remAmt;

   logic        accepting;
   logic [1:0]  acceptMode;
   logic [31:0] acceptWork;
   logic [5:0]  acceptRem;
   logic [5:0]  stepAmt;
   logic        lastStep;
   logic [31:0] shiftedWork;

   // Work out what a new request would load. Any amount with a bit set at
   // position 5 or above is 32 or more, so it clamps to 32; the invalid mode
   // loads a zero operand with nothing left to shift so it finishes at once.
   always_comb begin
      acceptMode = {op1, op2};
      accepting  = start && ((state == IDLE) || (state == DONE));
      acceptWork = a;
      acceptRem  = (|shiftamt[31:5]) ? 6'd32 : {1'b0, shiftamt[4:0]};
      if (acceptMode == 2'b11) begin
         acceptWork = 32'd0;
         acceptRem  = 6'd0;
      end
   end

   // One shift step: move by whatever is left, capped at STEP. When the
   // remaining amount fits in this step, this is the final cycle.
   always_comb begin
      stepAmt     = (remAmt < stepMax) ? remAmt : stepMax;
      lastStep    = (remAmt == stepAmt);
      shiftedWork = 32'd0;
      case (mode)
         2'b00:   shiftedWork = work << stepAmt;
         2'b10:   shiftedWork = work >> stepAmt;
         2'b01:   shiftedWork = $unsigned($signed(work) >>> stepAmt);
         default: shiftedWork = 32'd0;
      endcase
   end

   // State register; reset drops any request in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. DONE behaves like IDLE for accepting, which is what
   // allows back-to-back requests without an idle bubble.
   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               nextState = (acceptRem != 6'd0) ? SHIFT : DONE;
            end else begin
               nextState = IDLE;
            end
         end
         SHIFT: begin
            if (lastStep) begin
               nextState = DONE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath registers. res is written only on the edge that enters DONE:
   // either at accept for zero-length/invalid requests, or on the last step.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work   <= 32'd0;
         mode   <= 2'd0;
         remAmt <= 6'd0;
         res    <= 32'd0;
      end else if (accepting) begin
         work   <= acceptWork;
         mode   <= acceptMode;
         remAmt <= acceptRem;
         if (acceptRem == 6'd0) begin
            res <= acceptWork;
         end
      end else if (state == SHIFT) begin
         work   <= shiftedWork;
         remAmt <= remAmt - stepAmt;
         if (lastStep) begin
            res <= shiftedWork;
         end
      end
   end

   // Status flags are plain decodes of the registered state.
   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Directed and random requests against a whole-word reference shift.
//   Checks busy/done timing cycle by cycle, result value, result hold,
//   ignored start during SHIFT, back-to-back accept and asynchronous reset.
module tb_shift_sequencer;

   localparam int STEP = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] shiftamt;
   logic        op1;
   logic        op2;
   logic        busy;
   logic        done;
   logic [31:0] res;

   int          assertCount;
   int          failCount;
   logic [31:0] expRes;

   shift_sequencer #(.STEP(STEP)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .shiftamt (shiftamt),
      .op1      (op1),
      .op2      (op2),
      .busy     (busy),
      .done     (done),
      .res      (res)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Saturated shift amount as the reference sees it.
   function automatic int clampAmt(input logic [31:0] amt);
      return (amt >= 32'd32) ? 32 : int'(amt);
   endfunction

   // Number of SHIFT cycles expected for a request.
   function automatic int expCycles(input logic [31:0] amt, input logic o1, input logic o2);
      if ({o1, o2} == 2'b11) return 0;
      return (clampAmt(amt) + STEP - 1) / STEP;
   endfunction

   // Whole-word result in one go, straight from the mode definitions.
   function automatic logic [31:0] refShift(input logic [31:0] aIn, input logic [31:0] amt,
                                            input logic o1, input logic o2);
      int c;
      logic signed [31:0] s;
      c = clampAmt(amt);
      s = aIn;
      case ({o1, o2})
         2'b00:   return (c == 32) ? 32'd0 : (aIn << c);
         2'b10:   return (c == 32) ? 32'd0 : (aIn >> c);
         2'b01:   return (c == 32) ? {32{aIn[31]}} : $unsigned(s >>> c);
         default: return 32'd0;
      endcase
   endfunction

   // Single comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Issue one request from IDLE or DONE (called #1 after an edge), then
   // follow it to its done cycle. Optionally re-pulse start with junk data
   // during the first SHIFT cycle. Returns #1 after the edge entering DONE.
   task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] amtIn,
                                input logic o1, input logic o2, input bit repulse);
      int          n;
      logic [31:0] want;
      n    = expCycles(amtIn, o1, o2);
      want = refShift(aIn, amtIn, o1, o2);
      start    = 1'b1;
      a        = aIn;
      shiftamt = amtIn;
      op1      = o1;
      op2      = o2;
      @(posedge clk);
      #1;
      start    = 1'b0;
      a        = $urandom;
      shiftamt = $urandom;
      op1      = 1'($urandom);
      op2      = 1'($urandom);
      for (int i = 0; i < n; i++) begin
         checkOutput("busyInShift", {31'd0, busy}, 32'd1);
         checkOutput("doneInShift", {31'd0, done}, 32'd0);
         checkOutput("resHeld", res, expRes);
         if (repulse && i == 0) begin
            start    = 1'b1;
            a        = 32'hFFFF_FFFF;
            shiftamt = 32'd4;
            op1      = 1'b0;
            op2      = 1'b0;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      checkOutput("donePulse", {31'd0, done}, 32'd1);
      checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
      checkOutput("result", res, want);
      expRes = want;
   endtask

   // One cycle with no request: DONE or IDLE falls to IDLE, result holds.
   task automatic idleCycle();
      start = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idleDone", {31'd0, done}, 32'd0);
      checkOutput("idleBusy", {31'd0, busy}, 32'd0);
      checkOutput("idleRes", res, expRes);
   endtask

   initial begin
      assertCount = 0;
      failCount   = 0;
      expRes      = 32'd0;
      rst         = 1'b1;
      start       = 1'b0;
      a           = 32'd0;
      shiftamt    = 32'd0;
      op1         = 1'b0;
      op2         = 1'b0;

      // Reset state
      #1;
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstRes", res, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idleCycle();

      // Directed cases
      $display("[TB] directed requests");
      applyStimulus(32'h0000_0001, 32'd5, 1'b0, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'h8000_0000, 32'd31, 1'b0, 1'b1, 1'b0);
      idleCycle();
      applyStimulus(32'h8000_0000, 32'd31, 1'b1, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'h8000_0000, 32'd40, 1'b1, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'h8000_0000, 32'd40, 1'b0, 1'b1, 1'b0);
      idleCycle();
      applyStimulus(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
      idleCycle();
      applyStimulus(32'hDEAD_BEEF, 32'd7, 1'b1, 1'b1, 1'b0);
      idleCycle();
      applyStimulus(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
      idleCycle();

      // start during SHIFT ignored, then back-to-back accept from DONE
      $display("[TB] repulse and back-to-back");
      applyStimulus(32'h0000_00F0, 32'd8, 1'b1, 1'b0, 1'b1);
      applyStimulus(32'h0000_0003, 32'd1, 1'b0, 1'b0, 1'b0);
      idleCycle();

      // Asynchronous reset in the middle of a full-width shift
      $display("[TB] reset during shift");
      applyStimulus(32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
      start    = 1'b1;
      a        = 32'h8000_0000;
      shiftamt = 32'd32;
      op1      = 1'b0;
      op2      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("preRstBusy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("asyncBusy", {31'd0, busy}, 32'd0);
      checkOutput("asyncDone", {31'd0, done}, 32'd0);
      checkOutput("asyncRes", res, 32'd0);
      expRes = 32'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) idleCycle();
      applyStimulus(32'h0000_00A5, 32'd3, 1'b0, 1'b0, 1'b0);
      idleCycle();

      // Random requests, sometimes back-to-back, sometimes with repulse
      $display("[TB] random requests");
      for (int k = 0; k < 60; k++) begin
         logic [31:0] ra;
         logic [31:0] ramt;
         ra   = $urandom;
         ramt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
         applyStimulus(ra, ramt, 1'($urandom), 1'($urandom), bit'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idleCycle();
      end
      idleCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
